// File: rtl/branch_back_mc_if.sv
// branch_back_mc_if: bundle between branch-resolution producers, the writeback
// arbiter and the warp scheduler.
//   in_valid_i/in_ready_o  per-channel push handshake
//   in_wid_i/in_jump_i/in_new_pc_i  packed per-channel payload (channel k at [k*W +: W])
//   out_valid_o/out_ready_i  scheduler handshake
//   out_wid_o/out_jump_o/out_new_pc_o/out_ch_o  presented entry and its source channel
// master: the producer/scheduler side; slave: the arbiter.
`ifndef DEPTH_WARP
`define DEPTH_WARP 5
`endif

interface branch_back_mc_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned WID_W  = `DEPTH_WARP,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic [NUM_CH-1:0]       in_valid_i;
    logic [NUM_CH-1:0]       in_ready_o;
    logic [NUM_CH*WID_W-1:0] in_wid_i;
    logic [NUM_CH-1:0]       in_jump_i;
    logic [NUM_CH*PC_W-1:0]  in_new_pc_i;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic [WID_W-1:0]        out_wid_o;
    logic                    out_jump_o;
    logic [PC_W-1:0]         out_new_pc_o;
    logic [CH_W-1:0]         out_ch_o;

    modport master (
        output in_valid_i, in_wid_i, in_jump_i, in_new_pc_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_wid_o, out_jump_o, out_new_pc_o, out_ch_o
    );

    modport slave (
        input  in_valid_i, in_wid_i, in_jump_i, in_new_pc_i, out_ready_i,
        output in_ready_o, out_valid_o, out_wid_o, out_jump_o, out_new_pc_o, out_ch_o
    );
endinterface

// File: rtl/branch_back_mc.sv
// branch_back_mc: multi-channel branch-resolution writeback arbiter.
// Each producer channel pushes {wid, jump, new_pc} into its own FIFO; one head
// per cycle is forwarded to the warp scheduler under fixed or round-robin
// arbitration. A stalled grant is locked so the presented entry never changes
// before it is accepted.
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset (discards all queued entries)
//   bus  branch_back_mc_if.slave (producer pushes, scheduler pop port)
`ifndef DEPTH_WARP
`define DEPTH_WARP 5
`endif

module branch_back_mc #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned WID_W      = `DEPTH_WARP,
    parameter int unsigned PC_W       = 32,
    parameter int unsigned RR_MODE    = 0,
    parameter int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input logic             clk,
    input logic             rst,
    branch_back_mc_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [WID_W-1:0] wid;
        logic             jump;
        logic [PC_W-1:0]  pc;
    } entry_t;

    typedef enum logic {
        S_FREE = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    entry_t           mem    [NUM_CH][FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr [NUM_CH];
    logic [PTR_W-1:0] rd_ptr [NUM_CH];
    logic [CNT_W-1:0] count  [NUM_CH];

    state_t            state, state_n;
    logic [CH_W-1:0]   lock_ch, last_grant, grant, rr_idx;
    logic [NUM_CH-1:0] req, in_ready, push, pop;
    logic              out_valid, hs, found;
    entry_t            head;

    // Per-channel request/ready/push/pop; ready looks only at registered occupancy.
    always_comb begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            req[k]      = (count[k] != '0);
            in_ready[k] = !rst && (count[k] != CNT_W'(FIFO_DEPTH));
            push[k]     = bus.in_valid_i[k] && in_ready[k];
            pop[k]      = hs && (grant == CH_W'(k));
        end
    end

    assign bus.in_ready_o = in_ready;

    // FIFO pointers and occupancy; push and pop on one channel leave count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                count[k]  <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (push[k]) wr_ptr[k] <= wr_ptr[k] + PTR_W'(1);
                if (pop[k])  rd_ptr[k] <= rd_ptr[k] + PTR_W'(1);
                count[k] <= count[k] + CNT_W'(push[k]) - CNT_W'(pop[k]);
            end
        end
    end

    // FIFO storage is deliberately not reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (push[k]) begin
                mem[k][wr_ptr[k]] <= '{wid:  bus.in_wid_i[k*WID_W +: WID_W],
                                       jump: bus.in_jump_i[k],
                                       pc:   bus.in_new_pc_i[k*PC_W +: PC_W]};
            end
        end
    end

    // Lock state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FREE;
        else     state <= state_n;
    end

    // Lock engages on a stalled presentation and releases on handshake.
    always_comb begin
        state_n = state;
        case (state)
            S_FREE:  if (out_valid && !bus.out_ready_i) state_n = S_LOCK;
            S_LOCK:  if (bus.out_ready_i)               state_n = S_FREE;
            default: state_n = S_FREE;
        endcase
    end

    // Arbitration and output mux; a locked grant overrides any new requester.
    always_comb begin
        grant  = '0;
        rr_idx = '0;
        found  = 1'b0;
        head   = '0;
        if (state == S_LOCK) begin
            grant = lock_ch;
            found = 1'b1;
        end else if (RR_MODE == 0) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (req[k] && !found) begin
                    grant = CH_W'(k);
                    found = 1'b1;
                end
            end
        end else begin
            // Search begins just after the last granted channel, wrapping.
            for (int unsigned i = 1; i <= NUM_CH; i++) begin
                rr_idx = CH_W'((32'(last_grant) + i) % NUM_CH);
                if (req[rr_idx] && !found) begin
                    grant = rr_idx;
                    found = 1'b1;
                end
            end
        end

        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (grant == CH_W'(k)) head = mem[k][rd_ptr[k]];
        end

        out_valid = (state == S_LOCK) || (|req);
        hs        = out_valid && bus.out_ready_i;

        bus.out_valid_o  = out_valid;
        bus.out_wid_o    = out_valid ? head.wid  : '0;
        bus.out_jump_o   = out_valid ? head.jump : 1'b0;
        bus.out_new_pc_o = out_valid ? head.pc   : '0;
        bus.out_ch_o     = out_valid ? grant     : '0;
    end

    // Locked channel capture and round-robin history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_ch    <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
        end else begin
            if (state == S_FREE && state_n == S_LOCK) lock_ch <= grant;
            if (hs) last_grant <= grant;
        end
    end
endmodule

// File: tb/tb_branch_back_mc.sv
// tb_branch_back_mc: scoreboard bench for branch_back_mc. A fixed-priority
// 2-channel instance and a round-robin 3-channel instance share clk/rst.
// Stimulus pushes expected entries into per-instance queues; a negedge monitor
// pops and compares on every output handshake and checks output stability
// while stalled.
module tb_branch_back_mc;
    typedef struct packed {
        logic [4:0]  wid;
        logic        jump;
        logic [31:0] pc;
        logic [1:0]  ch;
    } rec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_back_mc_if #(.NUM_CH(2), .WID_W(5), .PC_W(32)) ifx ();
    branch_back_mc_if #(.NUM_CH(3), .WID_W(5), .PC_W(32)) irr ();

    branch_back_mc #(.NUM_CH(2), .FIFO_DEPTH(2), .WID_W(5), .PC_W(32), .RR_MODE(0))
        dut_fx (.clk(clk), .rst(rst), .bus(ifx));
    branch_back_mc #(.NUM_CH(3), .FIFO_DEPTH(2), .WID_W(5), .PC_W(32), .RR_MODE(1))
        dut_rr (.clk(clk), .rst(rst), .bus(irr));

    rec_t exp_fx[$];
    rec_t exp_rr[$];
    int   n_vec = 0;
    int   n_err = 0;

    bit         chk_idle_fx = 0, chk_rdy_fx = 0, chk_rdy_rr = 0, final_chk = 0;
    logic [1:0] exp_rdy_fx = '0;
    logic [2:0] exp_rdy_rr = '0;
    bit         stall_fx = 0, stall_rr = 0;
    rec_t       hold_fx, hold_rr;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: all comparisons happen here, on the falling edge.
    always @(negedge clk) begin
        rec_t a, e;
        if (chk_idle_fx)
            cmp("idle_fx", 64'({ifx.out_valid_o, ifx.out_wid_o, ifx.out_jump_o,
                                ifx.out_new_pc_o, ifx.out_ch_o}), 64'd0);
        if (chk_rdy_fx) cmp("in_ready_fx", 64'(ifx.in_ready_o), 64'(exp_rdy_fx));
        if (chk_rdy_rr) cmp("in_ready_rr", 64'(irr.in_ready_o), 64'(exp_rdy_rr));
        if (final_chk) begin
            cmp("left_fx", 64'(exp_fx.size()), 64'd0);
            cmp("left_rr", 64'(exp_rr.size()), 64'd0);
        end

        a = '{ifx.out_wid_o, ifx.out_jump_o, ifx.out_new_pc_o, 2'(ifx.out_ch_o)};
        if (rst) stall_fx = 1'b0;
        else begin
            if (stall_fx) cmp("hold_fx", 64'({ifx.out_valid_o, a}), 64'({1'b1, hold_fx}));
            if (ifx.out_valid_o && ifx.out_ready_i) begin
                if (exp_fx.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL out_fx: got ch%0d pc=%h, expected no entry", a.ch, a.pc);
                end else begin
                    e = exp_fx.pop_front();
                    cmp("out_fx", 64'(a), 64'(e));
                end
            end
            stall_fx = ifx.out_valid_o && !ifx.out_ready_i;
            hold_fx  = a;
        end

        a = '{irr.out_wid_o, irr.out_jump_o, irr.out_new_pc_o, irr.out_ch_o};
        if (rst) stall_rr = 1'b0;
        else begin
            if (stall_rr) cmp("hold_rr", 64'({irr.out_valid_o, a}), 64'({1'b1, hold_rr}));
            if (irr.out_valid_o && irr.out_ready_i) begin
                if (exp_rr.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL out_rr: got ch%0d pc=%h, expected no entry", a.ch, a.pc);
                end else begin
                    e = exp_rr.pop_front();
                    cmp("out_rr", 64'(a), 64'(e));
                end
            end
            stall_rr = irr.out_valid_o && !irr.out_ready_i;
            hold_rr  = a;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        chk_idle_fx = 0;
        chk_rdy_fx  = 0;
        chk_rdy_rr  = 0;
    endtask

    task automatic clr();
        ifx.in_valid_i = '0;
        irr.in_valid_i = '0;
    endtask

    task automatic put_fx(input int ch, input logic [4:0] w, input logic j,
                          input logic [31:0] pc, input bit expect_it);
        ifx.in_valid_i[ch]            = 1'b1;
        ifx.in_wid_i[ch*5 +: 5]       = w;
        ifx.in_jump_i[ch]             = j;
        ifx.in_new_pc_i[ch*32 +: 32]  = pc;
        if (expect_it) exp_fx.push_back('{w, j, pc, 2'(ch)});
    endtask

    task automatic put_rr(input int ch, input logic [4:0] w, input logic j,
                          input logic [31:0] pc);
        irr.in_valid_i[ch]            = 1'b1;
        irr.in_wid_i[ch*5 +: 5]       = w;
        irr.in_jump_i[ch]             = j;
        irr.in_new_pc_i[ch*32 +: 32]  = pc;
        exp_rr.push_back('{w, j, pc, 2'(ch)});
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (exp_fx.size() == 0 && exp_rr.size() == 0) break;
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int sent;
        rst = 1'b1;
        ifx.in_valid_i = '0; ifx.in_wid_i = '0; ifx.in_jump_i = '0; ifx.in_new_pc_i = '0;
        irr.in_valid_i = '0; irr.in_wid_i = '0; irr.in_jump_i = '0; irr.in_new_pc_i = '0;
        ifx.out_ready_i = 1'b1;
        irr.out_ready_i = 1'b1;

        // Reset state.
        step();
        chk_idle_fx = 1; chk_rdy_fx = 1; exp_rdy_fx = 2'b00; chk_rdy_rr = 1; exp_rdy_rr = 3'b000;
        step();
        rst = 1'b0;

        // Single channel, one-cycle latency, then idle zeros.
        put_fx(1, 5'd3, 1'b1, 32'h8000_0040, 1);
        chk_rdy_fx = 1; exp_rdy_fx = 2'b11; chk_rdy_rr = 1; exp_rdy_rr = 3'b111;
        step(); clr();
        step();
        chk_idle_fx = 1;
        step();

        // Fixed priority with lock: ch1 stays presented after ch0 arrives.
        ifx.out_ready_i = 1'b0;
        put_fx(1, 5'd1, 1'b0, 32'h100, 1); step(); clr();
        put_fx(0, 5'd2, 1'b1, 32'h200, 1); step(); clr();
        step(); step();
        ifx.out_ready_i = 1'b1;
        drain();
        chk_idle_fx = 1;
        step();

        // Backpressure: two accepted, ready drops, one pop restores it.
        ifx.out_ready_i = 1'b0;
        put_fx(0, 5'd4, 1'b0, 32'h300, 1); chk_rdy_fx = 1; exp_rdy_fx = 2'b11; step();
        put_fx(0, 5'd5, 1'b1, 32'h301, 1); chk_rdy_fx = 1; exp_rdy_fx = 2'b11; step();
        put_fx(0, 5'd6, 1'b0, 32'h302, 0); chk_rdy_fx = 1; exp_rdy_fx = 2'b10; step();
        chk_rdy_fx = 1; exp_rdy_fx = 2'b10; ifx.out_ready_i = 1'b1; step();
        ifx.out_ready_i = 1'b0;
        put_fx(0, 5'd6, 1'b0, 32'h302, 1); chk_rdy_fx = 1; exp_rdy_fx = 2'b11; step();
        clr(); chk_rdy_fx = 1; exp_rdy_fx = 2'b10; step();
        ifx.out_ready_i = 1'b1;
        drain();

        // Pointer wrap: ten entries through ch0 with alternating ready.
        sent = 0;
        for (int c = 0; c < 80 && sent < 10; c++) begin
            ifx.out_ready_i = c[0];
            if (ifx.in_ready_o[0]) begin
                put_fx(0, 5'(sent), sent[0], 32'h400 + 32'(sent), 1);
                sent++;
            end else begin
                clr();
            end
            step();
        end
        clr();
        ifx.out_ready_i = 1'b1;
        drain();

        // Round-robin fairness on three preloaded channels.
        irr.out_ready_i = 1'b0;
        for (int j = 0; j < 2; j++) begin
            for (int k = 0; k < 3; k++)
                put_rr(k, 5'(2*k + j), j[0], 32'h500 + 32'(16*k + j));
            step();
        end
        clr();
        step();
        irr.out_ready_i = 1'b1;
        drain();

        // Asynchronous reset with two entries queued and output stalled.
        ifx.out_ready_i = 1'b0;
        put_fx(0, 5'd7, 1'b1, 32'h600, 0);
        put_fx(1, 5'd8, 1'b0, 32'h601, 0);
        step(); clr(); step();
        #2;
        rst = 1'b1;
        chk_idle_fx = 1; chk_rdy_fx = 1; exp_rdy_fx = 2'b00; chk_rdy_rr = 1; exp_rdy_rr = 3'b000;
        step();
        rst = 1'b0;
        ifx.out_ready_i = 1'b1;
        chk_idle_fx = 1; chk_rdy_fx = 1; exp_rdy_fx = 2'b11; chk_rdy_rr = 1; exp_rdy_rr = 3'b111;
        step();
        for (int i = 0; i < 4; i++) begin
            chk_idle_fx = 1;
            step();
        end

        final_chk = 1;
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
